// File: rtl/riscof_sig_dumper.sv
// riscof_sig_dumper: snoops the data-memory write port for the RISCOF
// control cells, then streams the signature region out over valid/ready.
module riscof_sig_dumper #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_SIZE_WORDS = 1 << 19,
  parameter int unsigned TIMEOUT        = 1000000
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [3:0]            snp_we_i,
  input  logic [ADDR_WIDTH-1:0] snp_addr_i,
  input  logic [DATA_WIDTH-1:0] snp_wdata_i,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  output logic                  sig_valid_o,
  output logic [DATA_WIDTH-1:0] sig_data_o,
  output logic                  sig_last_o,
  input  logic                  sig_ready_i,
  output logic                  done_o,
  output logic                  timeout_o
);

  localparam int unsigned MW = $clog2(MEM_SIZE_WORDS * 4);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] HALT_A  = ADDR_WIDTH'((MEM_SIZE_WORDS - 3) * 4);
  localparam logic [ADDR_WIDTH-1:0] END_A   = ADDR_WIDTH'((MEM_SIZE_WORDS - 2) * 4);
  localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'((MEM_SIZE_WORDS - 1) * 4);

  typedef enum logic [2:0] {
    S_SNOOP,
    S_SETUP,
    S_READ,
    S_CAPT,
    S_SEND,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_start;
  logic [DATA_WIDTH-1:0] r_end;
  logic [DATA_WIDTH-1:0] r_halt;
  logic [DATA_WIDTH-1:0] r_buf;
  logic [CW-1:0]         r_cnt;
  logic                  r_timeout;
  // One spare bit so ptr+4 at the top of memory cannot wrap.
  logic [MW:0]           r_ptr;
  logic [MW:0]           r_lim;

  logic        w_halt_hit;
  logic        w_to_hit;
  logic        w_last;
  logic [MW:0] w_ptr0;
  logic [MW:0] w_lim0;

  function automatic logic [DATA_WIDTH-1:0] bmerge(input logic [DATA_WIDTH-1:0] old,
                                                   input logic [3:0]            we,
                                                   input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] v;
    v = old;
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) v[8*i +: 8] = d[8*i +: 8];
    end
    return v;
  endfunction

  assign w_halt_hit = (r_halt == DATA_WIDTH'(1));
  assign w_to_hit   = (r_cnt == CW'(TIMEOUT - 1));
  assign w_ptr0     = {1'b0, r_start[MW-1:0] & ~MW'(3)};
  assign w_lim0     = {1'b0, r_end[MW-1:0] & ~MW'(3)};
  assign w_last     = ((r_ptr + (MW+1)'(4)) >= r_lim);

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_SNOOP;
    else         r_state <= w_next;
  end

  // Shadow cells, cycle counter and timeout flag; only live while snooping.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_start   <= '0;
      r_end     <= '0;
      r_halt    <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_SNOOP) begin
      r_cnt <= r_cnt + CW'(1);
      if (w_to_hit && !w_halt_hit) r_timeout <= 1'b1;
      if (|snp_we_i) begin
        if (snp_addr_i[ADDR_WIDTH-1:2] == HALT_A[ADDR_WIDTH-1:2])
          r_halt <= bmerge(r_halt, snp_we_i, snp_wdata_i);
        if (snp_addr_i[ADDR_WIDTH-1:2] == END_A[ADDR_WIDTH-1:2])
          r_end <= bmerge(r_end, snp_we_i, snp_wdata_i);
        if (snp_addr_i[ADDR_WIDTH-1:2] == START_A[ADDR_WIDTH-1:2])
          r_start <= bmerge(r_start, snp_we_i, snp_wdata_i);
      end
    end
  end

  // Dump pointer, limit and output buffer.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ptr <= '0;
      r_lim <= '0;
      r_buf <= '0;
    end else begin
      case (r_state)
        S_SETUP: begin
          r_ptr <= w_ptr0;
          r_lim <= w_lim0;
        end
        S_CAPT: r_buf <= mem_rd_data_i;
        S_SEND: if (sig_ready_i) r_ptr <= r_ptr + (MW+1)'(4);
        default: ;
      endcase
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    w_next        = r_state;
    mem_rd_en_o   = 1'b0;
    mem_rd_addr_o = '0;
    sig_valid_o   = 1'b0;
    sig_data_o    = '0;
    sig_last_o    = 1'b0;
    done_o        = 1'b0;
    timeout_o     = r_timeout;
    case (r_state)
      S_SNOOP: if (w_halt_hit || w_to_hit) w_next = S_SETUP;
      S_SETUP: w_next = (w_ptr0 >= w_lim0) ? S_DONE : S_READ;
      S_READ: begin
        mem_rd_en_o   = 1'b1;
        mem_rd_addr_o = ADDR_WIDTH'(r_ptr);
        w_next        = S_CAPT;
      end
      S_CAPT: w_next = S_SEND;
      S_SEND: begin
        sig_valid_o = 1'b1;
        sig_data_o  = r_buf;
        sig_last_o  = w_last;
        if (sig_ready_i) w_next = w_last ? S_DONE : S_READ;
      end
      S_DONE: done_o = 1'b1;
      default: w_next = S_SNOOP;
    endcase
  end

endmodule

// File: tb/tb_riscof_sig_dumper.sv
// Testbench for riscof_sig_dumper: directed scenarios plus randomized dumps
// checked against a queue-based model of the signature region.
module tb_riscof_sig_dumper;

  localparam int unsigned MSW = 16;
  localparam int unsigned TO  = 100;
  localparam logic [31:0] A_HALT  = 32'h34;
  localparam logic [31:0] A_END   = 32'h38;
  localparam logic [31:0] A_START = 32'h3C;
  localparam logic [31:0] PMASK   = 32'h3C;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  snp_we;
  logic [31:0] snp_addr, snp_wdata;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr, mem_rd_data;
  logic        sig_valid, sig_last, sig_ready, done, tmo;
  logic [31:0] sig_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] mem [MSW];
  logic [31:0] m_start, m_end, m_halt;
  logic [31:0] word_q[$];
  logic [31:0] rd_q[$];

  riscof_sig_dumper #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_SIZE_WORDS(MSW),
    .TIMEOUT(TO)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .snp_we_i(snp_we),
    .snp_addr_i(snp_addr),
    .snp_wdata_i(snp_wdata),
    .mem_rd_en_o(mem_rd_en),
    .mem_rd_addr_o(mem_rd_addr),
    .mem_rd_data_i(mem_rd_data),
    .sig_valid_o(sig_valid),
    .sig_data_o(sig_data),
    .sig_last_o(sig_last),
    .sig_ready_i(sig_ready),
    .done_o(done),
    .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  // Second memory port: data valid one cycle after the strobe, garbage otherwise.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr[5:2]] : $urandom();

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [3:0] we,
                                         input logic [31:0] d);
    logic [31:0] m;
    m = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  task automatic check_idle_outs(input string tag);
    check({tag, "_ctl"}, {59'd0, mem_rd_en, sig_valid, sig_last, done, tmo}, 64'd0);
    check({tag, "_dat"}, {mem_rd_addr, sig_data}, 64'd0);
  endtask

  task automatic reset_dut();
    rstn      = 1'b0;
    snp_we    = 4'd0;
    snp_addr  = '0;
    snp_wdata = '0;
    sig_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outs("reset");
    rstn    = 1'b1;
    cyc     = 0;
    m_start = '0;
    m_end   = '0;
    m_halt  = '0;
  endtask

  // One snooped write; address low bits are noise the DUT must ignore.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] d);
    snp_addr  = addr | 32'($urandom_range(0, 3));
    snp_we    = we;
    snp_wdata = d;
    tick();
    snp_we = 4'd0;
    if (addr == A_HALT)  m_halt  = bmerge(m_halt, we, d);
    if (addr == A_END)   m_end   = bmerge(m_end, we, d);
    if (addr == A_START) m_start = bmerge(m_start, we, d);
  endtask

  task automatic build_expect();
    logic [31:0] p, l;
    word_q.delete();
    rd_q.delete();
    p = m_start & PMASK;
    l = m_end & PMASK;
    for (int unsigned a = p; a < l; a += 4) begin
      rd_q.push_back(a);
      word_q.push_back(mem[a >> 2]);
    end
  endtask

  // Observe one dump. lead = edges from now until the DUT enters setup.
  task automatic run_dump(input int lead, input int gap, input logic exp_to, input string tag);
    int   t       = 0;
    int   n_rd    = 0;
    int   first_v = -1;
    int   waitc   = 0;
    int   n_exp   = word_q.size();
    int   exp_done;
    logic got_done = 1'b0;
    exp_done = (n_exp == 0) ? lead + 1 : lead + 3 + (n_exp - 1) * (3 + gap) + gap + 1;
    while (!got_done && t < 600) begin
      tick();
      t++;
      if (t == lead) check({tag, "_timeout"}, {63'd0, tmo}, {63'd0, exp_to});
      if (mem_rd_en) begin
        if (rd_q.size() == 0) check({tag, "_extra_rd"}, 64'd1, 64'd0);
        else check({tag, "_rd_addr"}, {32'd0, mem_rd_addr}, {32'd0, rd_q.pop_front()});
        n_rd++;
      end
      if (sig_valid) begin
        if (first_v < 0) begin
          first_v = t;
          check({tag, "_latency"}, 64'(t), 64'(lead + 3));
        end
        if (word_q.size() == 0) check({tag, "_extra_word"}, 64'd1, 64'd0);
        else check({tag, "_word"}, {31'd0, sig_data, sig_last},
                   {31'd0, word_q[0], (word_q.size() == 1)});
        if (waitc < gap) begin
          sig_ready = 1'b0;
          waitc++;
        end else begin
          sig_ready = 1'b1;
          waitc     = 0;
          if (word_q.size() > 0) void'(word_q.pop_front());
        end
      end else begin
        sig_ready = 1'($urandom_range(0, 1));
      end
      if (done) got_done = 1'b1;
      // Writes after leaving snoop must have no effect on the dump.
      if (t >= lead && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       snp_addr = A_HALT;
          1:       snp_addr = A_END;
          default: snp_addr = A_START;
        endcase
        snp_we    = 4'($urandom_range(1, 15));
        snp_wdata = $urandom();
      end else begin
        snp_we = 4'd0;
      end
    end
    snp_we    = 4'd0;
    sig_ready = 1'b0;
    check({tag, "_done_seen"}, {63'd0, got_done}, 64'd1);
    check({tag, "_done_cycle"}, 64'(t), 64'(exp_done));
    check({tag, "_words_left"}, 64'(word_q.size()), 64'd0);
    check({tag, "_rd_count"}, 64'(n_rd), 64'(n_exp));
    check({tag, "_timeout_end"}, {63'd0, tmo}, {63'd0, exp_to});
  endtask

  task automatic scen_basic(input int gap, input string tag);
    do_write(A_START, 4'hF, 32'h10);
    do_write(A_END, 4'hF, 32'h18);
    do_write(A_HALT, 4'hF, 32'h1);
    build_expect();
    check({tag, "_model_n"}, 64'(word_q.size()), 64'd2);
    run_dump(1, gap, 1'b0, tag);
  endtask

  initial begin
    int ok;
    for (int i = 0; i < int'(MSW); i++) mem[i] = 32'hA0 + 32'(i);

    // Basic dump, then with backpressure.
    reset_dut();
    scen_basic(0, "basic");
    reset_dut();
    scen_basic(5, "backpr");

    // Byte-merge semantics on start and halt.
    reset_dut();
    do_write(A_START, 4'hF, 32'hFFFF_FF3C);
    do_write(A_START, 4'b0010, 32'h0000_2000);
    do_write(A_START, 4'b0001, 32'h0000_0008);
    do_write(A_START, 4'b1110, 32'h1234_56FF);
    do_write(A_END, 4'b0001, 32'hFFFF_FF14);
    do_write(A_HALT, 4'b0010, 32'h0000_0100);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("merge_nohalt", {62'd0, mem_rd_en, done}, 64'd0);
    end
    do_write(A_HALT, 4'b0010, 32'h0);
    do_write(A_HALT, 4'b0001, 32'hFFFF_FF01);
    build_expect();
    run_dump(1, 0, 1'b0, "merge");

    // Empty regions.
    reset_dut();
    do_write(A_START, 4'hF, 32'h20);
    do_write(A_END, 4'hF, 32'h20);
    do_write(A_HALT, 4'hF, 32'h1);
    build_expect();
    run_dump(1, 0, 1'b0, "empty_eq");
    reset_dut();
    do_write(A_START, 4'hF, 32'h24);
    do_write(A_END, 4'hF, 32'h20);
    do_write(A_HALT, 4'hF, 32'h1);
    build_expect();
    run_dump(1, 0, 1'b0, "empty_lt");

    // Timeout with zero shadows.
    reset_dut();
    while (cyc < int'(TO) - 1) tick();
    check("to_before", {62'd0, tmo, done}, 64'd0);
    build_expect();
    run_dump(1, 0, 1'b1, "timeout0");

    // Timeout with a populated region still dumps it.
    reset_dut();
    do_write(A_START, 4'hF, 32'h30);
    do_write(A_END, 4'hF, 32'h3C);
    while (cyc < int'(TO) - 1) tick();
    build_expect();
    run_dump(1, 1, 1'b1, "timeout_dump");

    // Halt and timeout coincide: halt wins, timeout stays low.
    reset_dut();
    do_write(A_START, 4'hF, 32'h04);
    do_write(A_END, 4'hF, 32'h08);
    while (cyc < int'(TO) - 2) tick();
    do_write(A_HALT, 4'hF, 32'h1);
    build_expect();
    run_dump(1, 0, 1'b0, "tie");

    // Reset while a word is on the stream.
    reset_dut();
    do_write(A_START, 4'hF, 32'h10);
    do_write(A_END, 4'hF, 32'h18);
    do_write(A_HALT, 4'hF, 32'h1);
    ok = 0;
    for (int i = 0; i < 10 && ok == 0; i++) begin
      tick();
      if (sig_valid) ok = 1;
    end
    check("midrst_valid_seen", 64'(ok), 64'd1);
    rstn = 1'b0;
    #1;
    check_idle_outs("midrst_async");
    reset_dut();
    scen_basic(2, "rerun");

    // Randomized regions, write orders and backpressure.
    for (int n = 0; n < 12; n++) begin
      logic [31:0] s, e;
      int          g;
      reset_dut();
      s = ($urandom() & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63));
      e = ($urandom() & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63));
      g = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        do_write(A_START, 4'hF, s);
        do_write(A_END, 4'hF, e);
      end else begin
        do_write(A_END, 4'hF, e);
        do_write(A_START, 4'hF, s);
      end
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 1) == 1) do_write(A_HALT, 4'hF, 32'h1);
      else do_write(A_HALT, 4'b0001, ($urandom() & 32'hFFFF_FF00) | 32'h01);
      build_expect();
      run_dump(1, g, 1'b0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
